muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequences the multi-cycle MULT/MULTU/DIV/DIVU operations issued from the EX stage, whose ALU control codes come from the decoder.
- Latches the operands, runs a fixed-latency multiply or a 32-iteration radix-2 divide, and holds the pipeline via stall_o.
- Presents the final HI/LO pair for one handshake window, then returns to idle.
- Sits beside the ALU in EX; its hi_o/lo_o feed the HI/LO register write port.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (pipelined multiplier depth); legal range 1..8.
- DATA_W, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- valid_i  in  1  EX holds a live instruction.
- alucontrol_i  in  5  ALU control code from the shared control-code defines; only MULT/MULTU/DIV/DIVU codes act.
- src_a_i  in  32  rs operand (dividend / multiplicand).
- src_b_i  in  32  rt operand (divisor / multiplier).
- flush_i  in  1  exception/eret flush of EX.
- ex_stall_ext_i  in  1  EX held by some other stall source.
- stall_o  out  1  request pipeline stall.
- result_valid_o  out  1  hi_o/lo_o are final; HI/LO write enable.
- hi_o  out  32  HI result (remainder / product upper).
- lo_o  out  32  LO result (quotient / product lower).

Behaviour:
- Reset: when resetn=0 at a clock edge, go to state IDLE with stall_o=0, result_valid_o=0, hi_o=0, lo_o=0, and clear the counters. This applies mid-operation and discards the partial result.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If valid_i and alucontrol_i is a muldiv code and !flush_i: stall_o=1 combinationally in the same cycle.
  - Latch operands and signedness. Latch absolute values for signed divide, plus quotient and remainder sign flags.
  - Next state is MUL, or DIV.
  - Divisor==0: next state is DONE directly, with LO=32'hFFFFFFFF and HI=src_a_i. Stall is 1 cycle.
- MUL:
  - stall_o=1 for MUL_LAT cycles, counted by cnt.
  - Product is 64-bit, signed (MULT) or unsigned (MULTU).
  - Next state is DONE. Total stall is MUL_LAT+1 cycles from issue.
- DIV:
  - One restoring iteration per cycle for 32 cycles, with stall_o=1.
  - On the last iteration, apply sign correction:
    - Quotient is negated if dividend and divisor signs differ.
    - Remainder takes the dividend's sign.
  - Total stall is 33 cycles.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- DONE:
  - stall_o=0 and result_valid_o=1; hi_o/lo_o are registered and stable.
  - If ex_stall_ext_i=1, remain in DONE and ignore valid_i (the same instruction is still in EX; it must not restart).
  - If ex_stall_ext_i=0, return to IDLE next cycle with result_valid_o=0.
- flush_i=1 in any state:
  - Forces stall_o=0 and result_valid_o=0 combinationally.
  - Next state is IDLE, and no HI/LO write occurs.
  - A flush in the issue cycle prevents the start.
- Non-muldiv codes, or valid_i=0, in IDLE: no action, stall_o=0.
- hi_o/lo_o hold their last value outside DONE. Consumers qualify them with result_valid_o.

Decomposition:
- The control codes MULT/MULTU/DIV/DIVU_CONTROL live in the shared defines2.vh; no new codes are added.
- State encoding is a localparam inside the module.
- Sub-module div_core: a 32-bit unsigned restoring-divide iteration datapath (partial remainder, quotient shift register, one step per enable). muldiv_ctrl owns the FSM, counter, sign handling and multiply.

Test Plan:
- DIVU a=100, b=7:
  - stall_o high exactly 33 cycles.
  - Then result_valid_o=1 with LO=14, HI=2.
  - With ex_stall_ext_i=0, back in IDLE next cycle.
- DIV a=0xFFFFFFF9 (-7), b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor zero: DIVU a=5, b=0 stalls 1 cycle, then LO=0xFFFFFFFF, HI=5.
- MULT a=0xFFFFFFFF, b=2, MUL_LAT=2:
  - stall 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands gives HI=1, LO=0xFFFFFFFE.
- Hold, flush and reset:
  - DIV with ex_stall_ext_i=1 held 4 cycles after DONE: result_valid_o stays 1 with no restart while valid_i stays 1.
  - flush_i at DIV iteration 10: stall_o drops the same cycle, no result_valid_o, state IDLE next cycle.
  - resetn=0 mid-MUL: all outputs 0 on the next edge.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared control codes and helpers for the multi-cycle multiply/divide sequencer.
package muldiv_ctrl_pkg;

  // Mirrors the MULT/MULTU/DIV/DIVU_CONTROL values of the shared ALU control-code defines.
  localparam logic [4:0] MULT_CONTROL  = 5'b10001;
  localparam logic [4:0] MULTU_CONTROL = 5'b10010;
  localparam logic [4:0] DIV_CONTROL   = 5'b10011;
  localparam logic [4:0] DIVU_CONTROL  = 5'b10100;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code == MULT_CONTROL) || (code == MULTU_CONTROL) ||
           (code == DIV_CONTROL)  || (code == DIVU_CONTROL);
  endfunction

  function automatic logic is_div(input logic [4:0] code);
    return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == MULT_CONTROL) || (code == DIV_CONTROL);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Unsigned radix-2 restoring divide datapath: one quotient bit per enabled cycle.
module div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);
  logic [DATA_W-1:0] rem, quo, dvs;
  logic [DATA_W:0]   shifted, diff;

  // Partial remainder stays below the divisor, so both outcomes fit DATA_W bits.
  always_comb begin
    shifted  = {rem, quo[DATA_W-1]};
    diff     = shifted - {1'b0, dvs};
    rem_next = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], ~diff[DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (en) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for MULT/MULTU/DIV/DIVU: stalls the pipe, computes HI/LO, presents them once.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_i,
  input  logic [4:0]        alucontrol_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              flush_i,
  input  logic              ex_stall_ext_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t            state, state_n;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] op_a, op_b;
  logic              op_signed, q_neg, r_neg;
  logic              issue, sgn_in, div_zero;
  logic [63:0]       ext_a, ext_b, product;
  logic [DATA_W-1:0] rem_next, quo_next;

  assign issue    = valid_i && is_muldiv(alucontrol_i) && !flush_i;
  assign sgn_in   = is_signed_op(alucontrol_i);
  assign div_zero = is_div(alucontrol_i) && (src_b_i == '0);

  // Truncated product of sign/zero-extended operands covers both MULT and MULTU.
  assign ext_a   = {{32{op_signed & op_a[31]}}, op_a};
  assign ext_b   = {{32{op_signed & op_b[31]}}, op_b};
  assign product = ext_a * ext_b;

  div_core #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (state == IDLE && issue),
    .en       (state == DIV),
    .dividend (abs32(src_a_i, sgn_in)),
    .divisor  (abs32(src_b_i, sgn_in)),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    state_n        = state;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      IDLE: if (issue) begin
        stall_o = 1'b1;
        state_n = div_zero ? DONE : (is_div(alucontrol_i) ? DIV : MUL);
      end
      MUL: begin
        stall_o = 1'b1;
        if (cnt == MUL_LAST) state_n = DONE;
      end
      DIV: begin
        stall_o = 1'b1;
        if (cnt == DIV_LAST) state_n = DONE;
      end
      DONE: begin
        result_valid_o = 1'b1;
        if (!ex_stall_ext_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush_i) begin
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      state_n        = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == MUL || state == DIV) ? cnt + 5'd1 : 5'd0;
      if (state == IDLE && issue) begin
        op_a      <= src_a_i;
        op_b      <= src_b_i;
        op_signed <= sgn_in;
        q_neg     <= sgn_in & (src_a_i[31] ^ src_b_i[31]);
        r_neg     <= sgn_in & src_a_i[31];
        if (div_zero) begin
          hi_o <= src_a_i;
          lo_o <= '1;
        end
      end
      // state_n already reflects flush, so a flushed op never writes HI/LO.
      if (state == MUL && state_n == DONE) {hi_o, lo_o} <= product;
      if (state == DIV && state_n == DONE) begin
        hi_o <= r_neg ? -rem_next : rem_next;
        lo_o <= q_neg ? -quo_next : quo_next;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;
  localparam int MUL_LAT = 2;

  logic        clk = 0, resetn = 0, valid = 0, flush = 0, ext = 0;
  logic [4:0]  ctl = '0;
  logic [31:0] a = '0, b = '0;
  logic        stall, rv;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid), .alucontrol_i(ctl),
    .src_a_i(a), .src_b_i(b), .flush_i(flush), .ex_stall_ext_i(ext),
    .stall_o(stall), .result_valid_o(rv), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mhi, output logic [31:0] mlo, output int lat);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lat = MUL_LAT + 1;
    p = '0;
    case (code)
      MULT_CONTROL:  p = 64'(sx * sy);
      MULTU_CONTROL: p = {32'b0, x} * {32'b0, y};
      default: begin
        lat = 33;
        if (y == 0) begin
          p = {x, 32'hFFFF_FFFF};
          lat = 1;
        end else if (code == DIV_CONTROL) p = {32'(sx % sy), 32'(sx / sy)};
        else p = {x % y, x / y};
      end
    endcase
    {mhi, mlo} = p;
  endfunction

  // Issue one op, measure stall length, check the result, then optionally hold DONE.
  task automatic run_op(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [31:0] ehi, elo;
    int lat, n;
    model(code, x, y, ehi, elo, lat);
    @(negedge clk); valid = 1; ctl = code; a = x; b = y; #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    check("stall_len", 64'(n), 64'(lat));
    check("rv_done", 64'(rv), 64'd1);
    check("hi", 64'(hi), 64'(ehi));
    check("lo", 64'(lo), 64'(elo));
    if (hold > 0) begin
      ext = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check("hold_rv", 64'(rv), 64'd1);
        check("hold_stall", 64'(stall), 64'd0);
        check("hold_lo", 64'(lo), 64'(elo));
      end
      ext = 0;
    end
    valid = 0;
    @(negedge clk); #1;
    check("idle_rv", 64'(rv), 64'd0);
    check("idle_stall", 64'(stall), 64'd0);
  endtask

  logic [4:0] codes [4];
  initial begin
    codes[0] = MULT_CONTROL; codes[1] = MULTU_CONTROL;
    codes[2] = DIV_CONTROL;  codes[3] = DIVU_CONTROL;

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rv", 64'(rv), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1;

    run_op(DIVU_CONTROL, 32'd100, 32'd7, 0);
    run_op(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(DIVU_CONTROL, 32'd5, 32'd0, 0);
    run_op(MULT_CONTROL, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(DIV_CONTROL, 32'd1234567, 32'hFFFF_FFF0, 4);

    // Non-muldiv code must not stall.
    @(negedge clk); valid = 1; ctl = 5'b00010; a = 32'd9; b = 32'd3; #1;
    check("nonmd_stall", 64'(stall), 64'd0);
    @(negedge clk); valid = 0;

    // Flush on the issue cycle blocks the start.
    @(negedge clk); valid = 1; ctl = DIVU_CONTROL; a = 32'd50; b = 32'd3; flush = 1; #1;
    check("flush_issue_stall", 64'(stall), 64'd0);
    @(negedge clk); flush = 0; valid = 0; #1;
    check("flush_issue_idle", 64'(stall), 64'd0);
    check("flush_issue_rv", 64'(rv), 64'd0);

    // Flush at the 10th divide iteration.
    @(negedge clk); valid = 1; ctl = DIV_CONTROL; a = 32'd77; b = 32'd5; #1;
    repeat (10) @(negedge clk);
    flush = 1; #1;
    check("flush_div_stall", 64'(stall), 64'd0);
    check("flush_div_rv", 64'(rv), 64'd0);
    @(negedge clk); flush = 0; valid = 0; #1;
    check("flush_div_idle_stall", 64'(stall), 64'd0);
    check("flush_div_idle_rv", 64'(rv), 64'd0);
    run_op(DIVU_CONTROL, 32'd1000, 32'd33, 0);

    // Reset during MUL clears everything.
    @(negedge clk); valid = 1; ctl = MULT_CONTROL; a = 32'd7; b = 32'd9;
    @(negedge clk); resetn = 0; valid = 0;
    @(negedge clk); #1;
    check("rst_mul_stall", 64'(stall), 64'd0);
    check("rst_mul_rv", 64'(rv), 64'd0);
    check("rst_mul_hilo", {hi, lo}, 64'd0);
    resetn = 1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(codes[$urandom_range(0, 3)], x, y, ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
